stable_window_checker: RTL and testbench
========================================

Name: stable_window_checker

Overview:
- Synthesizable companion to the team's simulation-only edge/stability assertions; it checks stability in hardware.
- Samples a single-bit monitored signal on every clock edge and reports rising and falling edges.
- Each transition is classified as clean or a glitch. Clean means the signal held its level for at least MIN_STABLE samples before the transition. Glitch means it did not.
- Sits directly downstream of the randomly-toggling stimulus driver. It replaces per-edge $rose-style checks with pass/fail counters readable by the bench or by status logic.

Parameters:
- MIN_STABLE, 3, required consecutive equal samples before a transition counts as clean. Legal range 2..(2**CNT_W - 1).
- CNT_W, 8, width of run_len, pass_cnt and fail_cnt.

Ports:
- clk  input  1  sampling clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  checker enable, sampled on clk.
- clr_cnt  input  1  synchronous clear of pass_cnt and fail_cnt.
- sig_in  input  1  monitored signal; must be stable around posedge clk.
- rose_o  output  1  one-cycle pulse: sample 1, previous sample 0.
- fell_o  output  1  one-cycle pulse: sample 0, previous sample 1.
- stable_o  output  1  high while in STABLE state.
- viol_o  output  1  one-cycle pulse on a glitch transition.
- run_len  output  CNT_W  consecutive equal samples at the current level, saturating.
- pass_cnt  output  CNT_W  count of clean transitions, saturating.
- fail_cnt  output  CNT_W  count of glitch transitions, saturating.

Behaviour:
- Reset: all outputs 0; internal prev = 0; state IDLE.
- All outputs are registered. Edge and classification results appear the cycle after the posedge that sampled sig_in (latency 1).
- States: IDLE, SETTLE, STABLE.
- IDLE
  - On posedge with en=1: prev <= sig_in, run_len <= 1, go to SETTLE.
  - No edge pulse is generated for this first sample.
- SETTLE, on posedge with en=1:
  - sig_in == prev: run_len++. If the new run_len >= MIN_STABLE, go to STABLE and set stable_o = 1 from the next cycle.
  - sig_in != prev: pulse rose_o or fell_o; pulse viol_o; fail_cnt++; prev <= sig_in; run_len <= 1; stay in SETTLE.
- STABLE, on posedge with en=1:
  - sig_in == prev: run_len++ (saturating at 2**CNT_W - 1); stable_o stays 1.
  - sig_in != prev: pulse rose_o or fell_o; pass_cnt++; prev <= sig_in; run_len <= 1; go to SETTLE; stable_o = 0 next cycle.
- en = 0 on any posedge:
  - Go to IDLE.
  - Clear rose_o, fell_o, viol_o, stable_o and run_len.
  - pass_cnt and fail_cnt hold.
- Pulses: rose_o, fell_o and viol_o are high for exactly one cycle per event.
  - rose_o and fell_o are never high together.
  - viol_o is only ever high together with rose_o or fell_o.
- Counters saturate at all-ones; no wrap-around.
- clr_cnt = 1 zeroes both counters at that posedge and overrides any increment in the same cycle. The transition pulses still fire.
- Asynchronous reset mid-run returns immediately to the reset values, including the counters.
- The first synchronous sample after reset release follows the IDLE rule.

Test Plan:
- Clean toggle:
  - Stimulus: rst_n released, en=1, sig_in held 0 for 4 cycles, then 1 for 4 cycles.
  - Required: one rose_o pulse, viol_o = 0, pass_cnt = 1, fail_cnt = 0.
  - Required: stable_o rises 1 cycle after the 3rd equal sample; run_len counts 1, 2, 3, 4, then returns to 1.
- Glitch:
  - Stimulus: from STABLE at 0, sig_in sequence 1, 0, 1, 1, 1.
  - Required: pass_cnt += 1 (first edge); fail_cnt += 2 (the two edges during SETTLE), each with viol_o; stable_o = 1 after the third consecutive 1.
- Saturation:
  - Stimulus: CNT_W = 4; hold sig_in for 20 cycles; then produce 20 clean transitions.
  - Required: run_len sticks at 15; pass_cnt sticks at 15.
- Clear collision:
  - Stimulus: clr_cnt = 1 on the same posedge as a clean transition with pass_cnt = 5.
  - Required: pass_cnt = 0 next cycle; rose_o or fell_o still pulses.
- Enable drop:
  - Stimulus: en = 0 while in STABLE with run_len = 6, then en = 1 with sig_in opposite to prev.
  - Required: run_len = 0 and stable_o = 0 while disabled; no edge pulse on re-enable; run_len = 1; counters unchanged.
- Async reset:
  - Stimulus: rst_n low mid-cycle with fail_cnt = 3.
  - Required: all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/stable_window_checker_if.sv
// Bundles the monitored signal, controls and status outputs of stable_window_checker.
// The master side drives sig_in/en/clr_cnt; the slave side is the checker.
interface stable_window_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             clr_cnt;
    logic             sig_in;
    logic             rose_o;
    logic             fell_o;
    logic             stable_o;
    logic             viol_o;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output en, clr_cnt, sig_in,
        input  rose_o, fell_o, stable_o, viol_o, run_len, pass_cnt, fail_cnt
    );

    modport slave (
        input  en, clr_cnt, sig_in,
        output rose_o, fell_o, stable_o, viol_o, run_len, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/stable_window_checker.sv
// Hardware stability checker: reports edges on sig_in and classifies each one as
// clean (level held >= MIN_STABLE samples beforehand) or a glitch.
//
// state  | meaning
// IDLE   | disabled or just reset; next enabled sample seeds prev, no edge reported
// SETTLE | current level held for fewer than MIN_STABLE samples; an edge here is a glitch
// STABLE | current level held for at least MIN_STABLE samples; an edge here is clean
module stable_window_checker #(
    parameter int MIN_STABLE = 3,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stable_window_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        STABLE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_STABLE);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic             prev_q, prev_d;
    logic             rose_q, rose_d;
    logic             fell_q, fell_d;
    logic             viol_q, viol_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic [CNT_W-1:0] run_inc;
    logic             sig_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            prev_q  <= 1'b0;
            rose_q  <= 1'b0;
            fell_q  <= 1'b0;
            viol_q  <= 1'b0;
            run_q   <= '0;
            pass_q  <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            rose_q  <= rose_d;
            fell_q  <= fell_d;
            viol_q  <= viol_d;
            run_q   <= run_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        rose_d  = 1'b0;
        fell_d  = 1'b0;
        viol_d  = 1'b0;
        run_d   = run_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        run_inc = (run_q == CNT_MAX) ? run_q : run_q + ONE;
        sig_chg = (bus.sig_in != prev_q);

        if (!bus.en) begin
            state_d = IDLE;
            run_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    prev_d  = bus.sig_in;
                    run_d   = ONE;
                    state_d = SETTLE;
                end
                SETTLE: begin
                    if (sig_chg) begin
                        rose_d = bus.sig_in;
                        fell_d = ~bus.sig_in;
                        viol_d = 1'b1;
                        fail_d = (fail_q == CNT_MAX) ? fail_q : fail_q + ONE;
                        prev_d = bus.sig_in;
                        run_d  = ONE;
                    end else begin
                        run_d = run_inc;
                        if (run_inc >= MIN_LEN) begin
                            state_d = STABLE;
                        end
                    end
                end
                STABLE: begin
                    if (sig_chg) begin
                        rose_d  = bus.sig_in;
                        fell_d  = ~bus.sig_in;
                        pass_d  = (pass_q == CNT_MAX) ? pass_q : pass_q + ONE;
                        prev_d  = bus.sig_in;
                        run_d   = ONE;
                        state_d = SETTLE;
                    end else begin
                        run_d = run_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end

        // Clear wins over a same-cycle increment; edge pulses are unaffected.
        if (bus.clr_cnt) begin
            pass_d = '0;
            fail_d = '0;
        end
    end

    assign bus.rose_o   = rose_q;
    assign bus.fell_o   = fell_q;
    assign bus.viol_o   = viol_q;
    assign bus.stable_o = (state_q == STABLE);
    assign bus.run_len  = run_q;
    assign bus.pass_cnt = pass_q;
    assign bus.fail_cnt = fail_q;

endmodule

// File: tb/tb_stable_window_checker.sv
// Directed bench for stable_window_checker (MIN_STABLE=3, CNT_W=4): a vector table
// for the single-cycle behaviour plus hand sequences for saturation and async reset.
module tb_stable_window_checker;

    localparam int CNT_W = 4;
    localparam int N_VEC = 32;

    typedef struct {
        int en;
        int clr;
        int sig;
        int rose;
        int fell;
        int stab;
        int viol;
        int run;
        int pass;
        int fail;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    vec_t vecs[N_VEC];

    stable_window_checker_if #(.CNT_W(CNT_W)) bus ();

    stable_window_checker #(.MIN_STABLE(3), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int rose, input int fell, input int stab,
                           input int viol, input int run, input int pass, input int fail);
        chk({tag, "_rose"},   int'(bus.rose_o),   rose);
        chk({tag, "_fell"},   int'(bus.fell_o),   fell);
        chk({tag, "_stable"}, int'(bus.stable_o), stab);
        chk({tag, "_viol"},   int'(bus.viol_o),   viol);
        chk({tag, "_run"},    int'(bus.run_len),  run);
        chk({tag, "_pass"},   int'(bus.pass_cnt), pass);
        chk({tag, "_fail"},   int'(bus.fail_cnt), fail);
    endtask

    task automatic step(input int en, input int clr, input int sig);
        bus.en      = (en != 0);
        bus.clr_cnt = (clr != 0);
        bus.sig_in  = (sig != 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.en      = 1'b0;
        bus.clr_cnt = 1'b0;
        bus.sig_in  = 1'b0;
        rst_n       = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int sig;
        checks = 0;
        errors = 0;

        //            en clr sig  rose fell stab viol run pass fail
        // clean toggle 0 -> 1
        vecs[0]  = '{1, 0, 0,  0, 0, 0, 0, 1, 0, 0};
        vecs[1]  = '{1, 0, 0,  0, 0, 0, 0, 2, 0, 0};
        vecs[2]  = '{1, 0, 0,  0, 0, 1, 0, 3, 0, 0};
        vecs[3]  = '{1, 0, 0,  0, 0, 1, 0, 4, 0, 0};
        vecs[4]  = '{1, 0, 1,  1, 0, 0, 0, 1, 1, 0};
        vecs[5]  = '{1, 0, 1,  0, 0, 0, 0, 2, 1, 0};
        vecs[6]  = '{1, 0, 1,  0, 0, 1, 0, 3, 1, 0};
        vecs[7]  = '{1, 0, 1,  0, 0, 1, 0, 4, 1, 0};
        // back to STABLE at 0
        vecs[8]  = '{1, 0, 0,  0, 1, 0, 0, 1, 2, 0};
        vecs[9]  = '{1, 0, 0,  0, 0, 0, 0, 2, 2, 0};
        vecs[10] = '{1, 0, 0,  0, 0, 1, 0, 3, 2, 0};
        // glitch: 1, 0, 1, 1, 1
        vecs[11] = '{1, 0, 1,  1, 0, 0, 0, 1, 3, 0};
        vecs[12] = '{1, 0, 0,  0, 1, 0, 1, 1, 3, 1};
        vecs[13] = '{1, 0, 1,  1, 0, 0, 1, 1, 3, 2};
        vecs[14] = '{1, 0, 1,  0, 0, 0, 0, 2, 3, 2};
        vecs[15] = '{1, 0, 1,  0, 0, 1, 0, 3, 3, 2};
        // two more clean edges to reach pass_cnt = 5
        vecs[16] = '{1, 0, 0,  0, 1, 0, 0, 1, 4, 2};
        vecs[17] = '{1, 0, 0,  0, 0, 0, 0, 2, 4, 2};
        vecs[18] = '{1, 0, 0,  0, 0, 1, 0, 3, 4, 2};
        vecs[19] = '{1, 0, 1,  1, 0, 0, 0, 1, 5, 2};
        vecs[20] = '{1, 0, 1,  0, 0, 0, 0, 2, 5, 2};
        vecs[21] = '{1, 0, 1,  0, 0, 1, 0, 3, 5, 2};
        vecs[22] = '{1, 0, 1,  0, 0, 1, 0, 4, 5, 2};
        vecs[23] = '{1, 0, 1,  0, 0, 1, 0, 5, 5, 2};
        vecs[24] = '{1, 0, 1,  0, 0, 1, 0, 6, 5, 2};
        // enable drop from STABLE run_len 6, re-enable with opposite level
        vecs[25] = '{0, 0, 1,  0, 0, 0, 0, 0, 5, 2};
        vecs[26] = '{0, 0, 0,  0, 0, 0, 0, 0, 5, 2};
        vecs[27] = '{1, 0, 0,  0, 0, 0, 0, 1, 5, 2};
        vecs[28] = '{1, 0, 0,  0, 0, 0, 0, 2, 5, 2};
        vecs[29] = '{1, 0, 0,  0, 0, 1, 0, 3, 5, 2};
        // clear colliding with a clean edge
        vecs[30] = '{1, 1, 1,  1, 0, 0, 0, 1, 0, 0};
        vecs[31] = '{1, 0, 1,  0, 0, 0, 0, 2, 0, 0};

        rst_n       = 1'b0;
        bus.en      = 1'b0;
        bus.clr_cnt = 1'b0;
        bus.sig_in  = 1'b0;
        #12;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < N_VEC; i++) begin
            step(vecs[i].en, vecs[i].clr, vecs[i].sig);
            chk_all($sformatf("vec%0d", i), vecs[i].rose, vecs[i].fell, vecs[i].stab,
                    vecs[i].viol, vecs[i].run, vecs[i].pass, vecs[i].fail);
        end

        // Saturation: run_len and pass_cnt stick at 15 with CNT_W = 4.
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1, 0, 0);
            chk($sformatf("sat_hold%0d_run", i), int'(bus.run_len), (i > 15) ? 15 : i);
        end
        sig = 0;
        for (int k = 0; k < 20; k++) begin
            sig = 1 - sig;
            step(1, 0, sig);
            chk($sformatf("sat_edge%0d_pass", k), int'(bus.pass_cnt), (k + 1 > 15) ? 15 : k + 1);
            step(1, 0, sig);
            step(1, 0, sig);
        end
        chk("sat_fail", int'(bus.fail_cnt), 0);
        chk("sat_stable", int'(bus.stable_o), 1);

        // Async reset mid-cycle with fail_cnt = 3.
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);
        chk_all("pre_arst", 0, 1, 0, 1, 1, 1, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst", 0, 0, 0, 0, 0, 0, 0);
        #1;
        rst_n = 1'b1;
        step(1, 0, 1);
        chk_all("post_arst", 0, 0, 0, 0, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
